// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine control path: FSM state codes,
// wash-mode indices and the front-panel state encoding.
package wm_pkg;

   localparam logic [2:0] FSM_IDLE  = 3'd0;
   localparam logic [2:0] FSM_SOAK  = 3'd2;
   localparam logic [2:0] FSM_WASH  = 3'd3;
   localparam logic [2:0] FSM_RINSE = 3'd4;
   localparam logic [2:0] FSM_SPIN  = 3'd5;

   localparam logic [1:0] MODE_QUICK  = 2'd0;
   localparam logic [1:0] MODE_NORMAL = 2'd1;
   localparam logic [1:0] MODE_HEAVY  = 2'd2;
   localparam logic [1:0] MODE_SPIN   = 2'd3;

   typedef enum logic [2:0] {
      P_READY,
      P_START_STB,
      P_WAIT_ACK,
      P_RUNNING,
      P_CANCEL_STB
   } panel_state_t;

endpackage

// File: rtl/wm_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer; also emits
// a one-cycle pulse on each debounced rising edge.
module wm_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // NOTE: the synchroniser flops are reset as well, so a level captured before reset never leaks out afterwards.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
         rise   <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            stable <= sync2;
            rise   <= sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/wm_panel_ctrl.sv
// Front-panel conditioner: debounced buttons and lid, one-hot mode register,
// start/cancel strobes with lid interlock and FSM start-acknowledge timeout.
module wm_panel_ctrl
   import wm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 4,
   parameter int START_HOLD_CYCLES = 5,
   parameter int ACK_TIMEOUT       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       power_on,
   input  logic       btn_start_raw,
   input  logic       btn_cancel_raw,
   input  logic       btn_mode_raw,
   input  logic       lid_raw,
   input  logic [2:0] fsm_state,
   output logic       start,
   output logic       cancel,
   output logic       lid,
   output logic       mode1,
   output logic       mode2,
   output logic       mode3,
   output logic       mode4,
   output logic       err_lid,
   output logic       err_nostart
);

   localparam int HOLD_W = $clog2(START_HOLD_CYCLES + 1);
   localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD_CYCLES - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

   logic start_lvl, start_rise, cancel_lvl, cancel_rise;
   logic mode_lvl, mode_rise, lid_lvl, lid_rise;
   logic db_unused;

   wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
      .clk(clk), .rst_n(rst_n), .raw(btn_start_raw), .stable(start_lvl), .rise(start_rise));
   wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
      .clk(clk), .rst_n(rst_n), .raw(btn_cancel_raw), .stable(cancel_lvl), .rise(cancel_rise));
   wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk(clk), .rst_n(rst_n), .raw(btn_mode_raw), .stable(mode_lvl), .rise(mode_rise));
   wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lid (
      .clk(clk), .rst_n(rst_n), .raw(lid_raw), .stable(lid_lvl), .rise(lid_rise));

   assign db_unused = ^{start_lvl, cancel_lvl, mode_lvl, lid_rise};

   logic start_press, cancel_press, mode_press, fsm_idle;

   assign start_press  = start_rise  & power_on;
   assign cancel_press = cancel_rise & power_on;
   assign mode_press   = mode_rise   & power_on;
   assign fsm_idle     = (fsm_state == FSM_IDLE);

   panel_state_t      state, state_d;
   logic [HOLD_W-1:0] hold_cnt, hold_d;
   logic [TO_W-1:0]   to_cnt, to_d;
   logic              err_lid_d, err_nostart_d, start_ok, mode_adv;
   logic [1:0]        mode_idx;

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state;
      hold_d        = '0;
      to_d          = '0;
      err_lid_d     = 1'b0;
      err_nostart_d = 1'b0;
      start_ok      = 1'b0;
      case (state)
         P_READY: begin
            if (start_press && !cancel_press && fsm_idle) begin
               if (lid_lvl) begin
                  err_lid_d = 1'b1;
               end else begin
                  state_d  = P_START_STB;
                  start_ok = 1'b1;
               end
            end
         end
         P_START_STB: begin
            if (cancel_press)           state_d = P_CANCEL_STB;
            else if (hold_cnt == HOLD_LAST) state_d = P_WAIT_ACK;
            else                        hold_d  = hold_cnt + 1'b1;
         end
         P_WAIT_ACK: begin
            if (cancel_press) begin
               state_d = P_CANCEL_STB;
            end else if (!fsm_idle) begin
               state_d = P_RUNNING;
            end else if (to_cnt == TO_LAST) begin
               state_d       = P_READY;
               err_nostart_d = 1'b1;
            end else begin
               to_d = to_cnt + 1'b1;
            end
         end
         P_RUNNING: begin
            if (cancel_press)  state_d = P_CANCEL_STB;
            else if (fsm_idle) state_d = P_READY;
         end
         P_CANCEL_STB: begin
            if (hold_cnt == HOLD_LAST) state_d = fsm_idle ? P_READY : P_RUNNING;
            else                       hold_d  = hold_cnt + 1'b1;
         end
         default: state_d = P_READY;
      endcase
      // A start accepted this cycle takes precedence over a simultaneous mode press.
      mode_adv = mode_press && (state == P_READY) && fsm_idle && !start_ok;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= P_READY;
         hold_cnt    <= '0;
         to_cnt      <= '0;
         err_lid     <= 1'b0;
         err_nostart <= 1'b0;
         mode_idx    <= MODE_QUICK;
         lid         <= 1'b0;
      end else if (power_on) begin
         state       <= state_d;
         hold_cnt    <= hold_d;
         to_cnt      <= to_d;
         err_lid     <= err_lid_d;
         err_nostart <= err_nostart_d;
         mode_idx    <= mode_adv ? mode_idx + 2'd1 : mode_idx;
         lid         <= lid_lvl;
      end
   end

   assign start  = (state == P_START_STB);
   assign cancel = (state == P_CANCEL_STB);
   assign mode1  = (mode_idx == MODE_QUICK);
   assign mode2  = (mode_idx == MODE_NORMAL);
   assign mode3  = (mode_idx == MODE_HEAVY);
   assign mode4  = (mode_idx == MODE_SPIN);

endmodule

// File: tb/tb_wm_panel_ctrl.sv
// Self-checking bench for wm_panel_ctrl: a timestamp-style panel model checked
// every cycle, plus directed scenarios with hand-computed latencies and widths.
module tb_wm_panel_ctrl;
   import wm_pkg::*;

   localparam int HOLD = 5;
   localparam int ACK  = 16;

   logic       clk = 1'b0;
   logic       rst_n, power_on;
   logic       btn_start_raw, btn_cancel_raw, btn_mode_raw, lid_raw;
   logic [2:0] fsm_state;
   logic       start, cancel, lid, mode1, mode2, mode3, mode4, err_lid, err_nostart;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   wm_panel_ctrl #(.DEBOUNCE_CYCLES(4), .START_HOLD_CYCLES(HOLD), .ACK_TIMEOUT(ACK)) dut (
      .clk(clk), .rst_n(rst_n), .power_on(power_on),
      .btn_start_raw(btn_start_raw), .btn_cancel_raw(btn_cancel_raw),
      .btn_mode_raw(btn_mode_raw), .lid_raw(lid_raw), .fsm_state(fsm_state),
      .start(start), .cancel(cancel), .lid(lid),
      .mode1(mode1), .mode2(mode2), .mode3(mode3), .mode4(mode4),
      .err_lid(err_lid), .err_nostart(err_nostart));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Model: raw sample history per input (0 start, 1 cancel, 2 mode, 3 lid),
   // panel expressed as remaining-cycle budgets for each strobe/wait window.
   bit h[4][5];
   bit m_stb[4], m_press[4];
   int m_mode, start_left, cancel_left, ack_left;
   bit running, e_lid, e_ns, m_lid;
   bit model_ok = 1'b0;

   always @(posedge clk) begin : model
      bit [3:0] raw_now;
      bit idle, ready, sp, cp, mp, acc, flip;
      raw_now = {lid_raw, btn_mode_raw, btn_cancel_raw, btn_start_raw};
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            m_stb[i] = 1'b0; m_press[i] = 1'b0;
            for (int j = 0; j < 5; j++) h[i][j] = 1'b0;
         end
         m_mode = 0; start_left = 0; cancel_left = 0; ack_left = 0;
         running = 1'b0; e_lid = 1'b0; e_ns = 1'b0; m_lid = 1'b0; model_ok = 1'b1;
      end else begin
         if (power_on) begin
            idle  = (fsm_state == FSM_IDLE);
            sp = m_press[0]; cp = m_press[1]; mp = m_press[2];
            ready = (start_left == 0 && cancel_left == 0 && ack_left == 0 && !running);
            acc = 1'b0; e_lid = 1'b0; e_ns = 1'b0;
            if (cp && (start_left > 0 || ack_left > 0 || running)) begin
               start_left = 0; ack_left = 0; running = 1'b0; cancel_left = HOLD;
            end else if (cancel_left > 0) begin
               cancel_left--;
               if (cancel_left == 0) running = !idle;
            end else if (start_left > 0) begin
               start_left--;
               if (start_left == 0) ack_left = ACK;
            end else if (ack_left > 0) begin
               if (!idle) begin
                  ack_left = 0; running = 1'b1;
               end else begin
                  ack_left--;
                  if (ack_left == 0) e_ns = 1'b1;
               end
            end else if (running) begin
               if (idle) running = 1'b0;
            end else if (sp && !cp && idle) begin
               if (m_stb[3]) e_lid = 1'b1;
               else begin start_left = HOLD; acc = 1'b1; end
            end
            if (ready && idle && mp && !acc) m_mode = (m_mode + 1) % 4;
            m_lid = m_stb[3];
         end
         // Stable flips once the last four synchronised samples all disagree with it.
         for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int j = 1; j < 5; j++) if (h[i][j] == m_stb[i]) flip = 1'b0;
            m_press[i] = flip && !m_stb[i];
            if (flip) m_stb[i] = !m_stb[i];
            for (int j = 4; j > 0; j--) h[i][j] = h[i][j-1];
            h[i][0] = raw_now[i];
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("start",       int'(start),       int'(start_left > 0));
         check("cancel",      int'(cancel),      int'(cancel_left > 0));
         check("lid",         int'(lid),         int'(m_lid));
         check("mode",        int'({mode4, mode3, mode2, mode1}), 1 << m_mode);
         check("err_lid",     int'(err_lid),     int'(e_lid));
         check("err_nostart", int'(err_nostart), int'(e_ns));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input int which, input logic v);
      case (which)
         0:       btn_start_raw  = v;
         1:       btn_cancel_raw = v;
         2:       btn_mode_raw   = v;
         default: lid_raw        = v;
      endcase
   endtask

   task automatic press(input int which, input int hold);
      set_btn(which, 1'b1);
      fork
         begin
            repeat (hold) @(posedge clk);
            #1 set_btn(which, 1'b0);
         end
      join_none
   endtask

   task automatic seek_rise(input bit use_cancel, output int lat);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if ((use_cancel ? cancel : start) == 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic strobe_width(input bit use_cancel, output int w);
      w = 0;
      while ((use_cancel ? cancel : start) == 1'b1 && w < 20) begin
         w++;
         tick();
      end
   endtask

   int lat, w, n_a, n_b, n_c;

   initial begin
      rst_n = 1'b0; power_on = 1'b1; fsm_state = FSM_IDLE;
      btn_start_raw = 1'b0; btn_cancel_raw = 1'b0; btn_mode_raw = 1'b0; lid_raw = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      check("rst_mode", int'({mode4, mode3, mode2, mode1}), 'b0001);
      check("rst_start", int'(start), 0);
      check("rst_cancel", int'(cancel), 0);
      check("rst_err_lid", int'(err_lid), 0);
      check("rst_err_nostart", int'(err_nostart), 0);

      repeat (2) begin
         press(2, 10);
         repeat (20) tick();
      end
      check("mode_two_presses", int'({mode4, mode3, mode2, mode1}), 'b0100);
      press(2, 3);
      repeat (15) tick();
      check("mode_glitch", int'({mode4, mode3, mode2, mode1}), 'b0100);

      press(0, 10);
      seek_rise(1'b0, lat);
      check("start_latency", lat, 7);
      strobe_width(1'b0, w);
      check("start_width", w, HOLD);
      repeat (2) tick();
      fsm_state = FSM_SOAK;
      repeat (5) tick();
      press(2, 10);
      repeat (20) tick();
      check("mode_while_running", int'({mode4, mode3, mode2, mode1}), 'b0100);
      fsm_state = FSM_IDLE;
      repeat (3) tick();

      lid_raw = 1'b1;
      repeat (10) tick();
      check("lid_open", int'(lid), 1);
      press(0, 10);
      n_a = 0; n_b = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         n_a += int'(err_lid);
         n_b += int'(start);
      end
      check("err_lid_pulses", n_a, 1);
      check("start_with_lid_open", n_b, 0);
      lid_raw = 1'b0;
      repeat (10) tick();
      check("lid_closed", int'(lid), 0);

      press(0, 10);
      seek_rise(1'b0, lat);
      check("noack_start_latency", lat, 7);
      strobe_width(1'b0, w);
      check("noack_start_width", w, HOLD);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (err_nostart) begin lat = i; break; end
      end
      check("nostart_latency", lat, ACK);
      tick();
      check("nostart_one_cycle", int'(err_nostart), 0);

      repeat (5) tick();
      press(0, 10);
      seek_rise(1'b0, lat);
      check("restart_latency", lat, 7);
      strobe_width(1'b0, w);
      repeat (2) tick();
      fsm_state = FSM_WASH;
      repeat (5) tick();

      power_on = 1'b0;
      press(1, 10);
      n_a = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         n_a += int'(cancel);
      end
      check("cancel_while_off", n_a, 0);
      power_on = 1'b1;
      repeat (5) tick();
      press(1, 10);
      seek_rise(1'b1, lat);
      check("cancel_latency", lat, 7);
      strobe_width(1'b1, w);
      check("cancel_width", w, HOLD);
      fsm_state = FSM_IDLE;
      repeat (3) tick();
      press(2, 10);
      repeat (20) tick();
      check("mode_after_cancel", int'({mode4, mode3, mode2, mode1}), 'b1000);

      press(0, 10);
      repeat (3) tick();
      press(1, 10);
      n_a = 0; n_b = 0; n_c = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         n_a += int'(start && cancel);
         n_b += int'(start);
         n_c += int'(cancel);
      end
      check("strobe_overlap", n_a, 0);
      check("start_cut_by_cancel", n_b, 3);
      check("cancel_after_start", n_c, HOLD);

      repeat (10) tick();
      press(0, 10);
      seek_rise(1'b0, lat);
      check("pre_reset_start", lat, 7);
      tick();
      rst_n = 1'b0;
      tick();
      check("start_aborted_by_reset", int'(start), 0);
      check("mode_after_reset", int'({mode4, mode3, mode2, mode1}), 'b0001);
      rst_n = 1'b1;
      repeat (15) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog at cycle %0d: bench did not finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
